// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
//
// Purpose:
//   I2S transmitter toward the DAC. Divides the system clock down to the bit
//   clock, generates word select (l_r_clk), accepts stereo sample pairs through
//   a valid/ready handshake into a one-entry holding register and shifts each
//   frame out MSB-first with the usual one-bclk I2S data delay.
//
// Configuration macro:
//   I2S_TX_MONO_EN - when defined, right_sample is ignored and left_sample is
//                    sent in both slots. Port list is identical in both builds.
//
// Parameters:
//   BCLK_HALF  - clk cycles per bclk half period (>= 1)
//   SLOT_BITS  - bclk periods per channel slot (>= 16), unused bits are zero
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   left_sample  in   16-bit signed left sample
//   right_sample in   16-bit signed right sample
//   in_valid     in   sample pair presented
//   in_ready     out  holding register empty
//   bclk         out  I2S bit clock
//   l_r_clk      out  word select, 0 = left, 1 = right
//   sdata        out  serial data, changes on bclk falling edges
//   frame_start  out  one-clk pulse per frame load
//   underrun     out  sticky: a frame was loaded with the holding register empty
// -----------------------------------------------------------------------------
module i2s_tx #(
    parameter int BCLK_HALF = 2,
    parameter int SLOT_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] left_sample,
    input  logic [15:0] right_sample,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bclk,
    output logic        l_r_clk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int HW         = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BW         = $clog2(FRAME_BITS);

    localparam logic [HW-1:0] HALF_LAST = HW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] SLOT_W    = BW'(SLOT_BITS);

    // Divider / timing state
    logic [HW-1:0]         r_half_cnt;
    logic                  r_bclk;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_lr;
    logic                  r_sdata;
    logic [FRAME_BITS-1:0] r_shift;

    // Sample path state
    logic                  r_hold_full;
    logic [15:0]           r_hold_l;
    logic [15:0]           r_hold_r;
    logic [15:0]           r_last_l;
    logic [15:0]           r_last_r;
    logic                  r_underrun;
    logic                  r_frame_start;

    logic                  w_tc;
    logic                  w_fall;
    logic                  w_wrap;
    logic                  w_load;
    logic                  w_xfer;
    logic [BW-1:0]         w_bit_next;
    logic [15:0]           w_load_l;
    logic [15:0]           w_load_r;
    logic [FRAME_BITS-1:0] w_img;

    assign w_tc       = (r_half_cnt == HALF_LAST);
    // bclk is about to go 1 -> 0: the only moment data and word select move.
    assign w_fall     = w_tc & r_bclk;
    assign w_wrap     = (r_bit_cnt == BIT_LAST);
    assign w_load     = w_fall & w_wrap;
    assign w_bit_next = w_wrap ? '0 : r_bit_cnt + 1'b1;
    // in_ready is a pure register output, so the handshake has no
    // combinational input-to-output path.
    assign w_xfer     = in_valid & ~r_hold_full;

    // A frame load with an empty holding register repeats the last pair sent.
    // A transfer landing on the load edge is not visible yet, so it waits
    // for the following frame.
    assign w_load_l = r_hold_full ? r_hold_l : r_last_l;
    assign w_load_r = r_hold_full ? r_hold_r : r_last_r;

    // Frame image {left, zeros, right, zeros}, each sample MSB-first in its slot.
    assign w_img = (FRAME_BITS'(w_load_l) << (FRAME_BITS - 16))
                 | (FRAME_BITS'(w_load_r) << (SLOT_BITS - 16));

    // Bit clock divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_half_cnt <= '0;
            r_bclk     <= 1'b0;
        end else if (w_tc) begin
            r_half_cnt <= '0;
            r_bclk     <= ~r_bclk;
        end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
        end
    end

    // Bit counter, word select and shifter. The bit counter starts at its last
    // value so the first fall event after reset wraps it and starts a frame.
    // sdata takes the MSB before the shift/load, which is what delays the
    // data one bclk behind l_r_clk: bit 0 of a frame still carries the last
    // bit of the previous frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= BIT_LAST;
            r_lr      <= 1'b1;
            r_sdata   <= 1'b0;
            r_shift   <= '0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lr      <= (w_bit_next >= SLOT_W);
            r_sdata   <= r_shift[FRAME_BITS-1];
            if (w_wrap) begin
                r_shift <= w_img;
            end else begin
                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // Holding register, last-pair store, underrun and frame_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_last_l      <= '0;
            r_last_r      <= '0;
            r_underrun    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;

            if (w_load) begin
                if (r_hold_full) begin
                    r_last_l <= r_hold_l;
                    r_last_r <= r_hold_r;
                end else begin
                    r_underrun <= 1'b1;
                end
            end

            // A transfer needs an empty register, so it never collides with a
            // load that drains a full one.
            if (w_xfer) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= left_sample;
`ifdef I2S_TX_MONO_EN
                r_hold_r    <= left_sample;
`else
                r_hold_r    <= right_sample;
`endif
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign in_ready    = ~r_hold_full;
    assign bclk        = r_bclk;
    assign l_r_clk     = r_lr;
    assign sdata       = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
//
// Self-checking bench for i2s_tx (BCLK_HALF=2, SLOT_BITS=16). A reference
// model derives every output from the clk-edge count since reset release:
// frames start at edge 2*BCLK_HALF and repeat every 4*BCLK_HALF*SLOT_BITS
// edges, and each fall event emits one bit of the current frame image.
// Directed scenarios (reset, stereo pattern, backpressure, underrun,
// simultaneous transfer/load, mid-frame reset) are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int BH      = 2;
    localparam int S       = 16;
    localparam int FB      = 2 * S;
    localparam int FIRST   = 2 * BH;        // edge of first fall / frame load
    localparam int BPER    = 2 * BH;        // clk edges per bclk period

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [15:0] left_sample  = '0;
    logic [15:0] right_sample = '0;
    logic        in_valid     = 1'b0;
    logic        in_ready;
    logic        bclk;
    logic        l_r_clk;
    logic        sdata;
    logic        frame_start;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    i2s_tx #(.BCLK_HALF(BH), .SLOT_BITS(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bclk         (bclk),
        .l_r_clk      (l_r_clk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FB-1:0] make_img(input logic [15:0] l, input logic [15:0] r);
        return (FB'(l) << (FB - 16)) | (FB'(r) << (S - 16));
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int          m_n       = 0;     // clk edges since reset release
    logic        m_full    = 1'b0;
    logic [15:0] m_hl      = '0;
    logic [15:0] m_hr      = '0;
    logic [15:0] m_ll      = '0;
    logic [15:0] m_lr_smp  = '0;
    logic        m_und     = 1'b0;
    logic        m_fs      = 1'b0;
    logic        m_bclk    = 1'b0;
    logic        m_lr      = 1'b1;
    logic        m_sd      = 1'b0;
    logic [FB-1:0] m_prev  = '0;
    logic [FB-1:0] m_cur   = '0;
    logic        m_full_b;
    int          m_k;
    int          m_b;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_n = 0; m_full = 0; m_hl = 0; m_hr = 0; m_ll = 0; m_lr_smp = 0;
            m_und = 0; m_fs = 0; m_bclk = 0; m_lr = 1; m_sd = 0;
            m_prev = '0; m_cur = '0;
        end else begin
            m_n++;
            m_full_b = m_full;
            m_fs = 1'b0;
            if (m_n % BH == 0) m_bclk = ~m_bclk;
            if (m_n >= FIRST && ((m_n - FIRST) % BPER) == 0) begin
                m_k = (m_n - FIRST) / BPER;
                m_b = m_k % FB;
                if (m_b == 0) begin
                    m_fs   = 1'b1;
                    m_prev = m_cur;
                    if (m_full) begin
                        m_ll = m_hl; m_lr_smp = m_hr; m_full = 1'b0;
                    end else begin
                        m_und = 1'b1;
                    end
                    m_cur = make_img(m_ll, m_lr_smp);
                    m_sd  = m_prev[0];
                end else begin
                    m_sd = m_cur[FB - m_b];
                end
                m_lr = (m_b >= S);
            end
            if (in_valid && !m_full_b) begin
                m_hl = left_sample;
`ifdef I2S_TX_MONO_EN
                m_hr = left_sample;
`else
                m_hr = right_sample;
`endif
                m_full = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare every output on the falling clk edge
    // ------------------------------------------------------------------
    logic rb [0:63];
    int   rc = 0;
    logic prev_bclk = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("bclk",        bclk,        m_bclk);
            check("l_r_clk",     l_r_clk,     m_lr);
            check("sdata",       sdata,       m_sd);
            check("frame_start", frame_start, m_fs);
            check("in_ready",    in_ready,    !m_full);
            check("underrun",    underrun,    m_und);
            if (bclk === 1'b1 && prev_bclk === 1'b0 && rc < 64) begin
                rb[rc] = sdata;
                rc++;
            end
        end
        prev_bclk = bclk;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called right after a falling clk edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int g;
        g = 0;
        left_sample  = l;
        right_sample = r;
        in_valid     = 1'b1;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("xfer_wait", (g < 300), 1'b1);
        @(negedge clk);
        $display("xfer L=%h R=%h after %0d wait cycles (edge %0d)", l, r, g, m_n);
    endtask

    task automatic wait_n(input int t);
        int g;
        g = 0;
        while (m_n < t && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("wait_edge", (m_n >= t), 1'b1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_bclk"},     bclk,        1'b0);
        check({tag, "_l_r_clk"},  l_r_clk,     1'b1);
        check({tag, "_sdata"},    sdata,       1'b0);
        check({tag, "_in_ready"}, in_ready,    1'b1);
        check({tag, "_underrun"}, underrun,    1'b0);
        check({tag, "_fs"},       frame_start, 1'b0);
    endtask

    logic [15:0] pat_l;
    logic [15:0] pat_r;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        #1 reset = 1'b0;

        // Stereo pattern, then two back-to-back pairs (backpressure),
        // then a single pair followed by silence (underrun).
        send(16'hA5C3, 16'h3C5A);
        send(16'h1357, 16'h9BDF);
        send(16'h2468, 16'hACE0);
        send(16'h7FFF, 16'h8000);
        in_valid = 1'b0;

        // Stereo bit pattern as the DAC would latch it on bclk rises
        wait_n(FIRST + 3 * BPER * FB);
        for (int i = 0; i < 16; i++) begin
            pat_l[15 - i] = rb[2 + i];
            pat_r[15 - i] = rb[18 + i];
        end
        check("stereo_left",  pat_l, 16'hA5C3);
        check("stereo_right", pat_r, 16'h3C5A);

        // Mid-frame reset at bit 9 of the right slot of frame 5
        wait_n(FIRST + BPER * (FB * 5 + S + 9));
        check("underrun_sticky", underrun, 1'b1);
        check("pre_rst_l_r_clk", l_r_clk, 1'b1);
        #1 reset = 1'b1;
        #1 check_reset_outs("midrst");
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Transfer exactly on the first load edge: that frame underruns
        wait_n(FIRST - 1);
        left_sample  = 16'h1234;
        right_sample = 16'hFEDC;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("xfer L=1234 R=FEDC on load edge %0d", m_n);
        check("simul_underrun", underrun, 1'b1);
        check("simul_held",     in_ready, 1'b0);
        check("simul_fs",       frame_start, 1'b1);
        wait_n(FIRST + 2 * BPER * FB + 8);

        // Random traffic with random gaps
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 90)) @(negedge clk);
            send(16'($urandom), 16'($urandom));
            in_valid = 1'b0;
        end
        repeat (2 * BPER * FB) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
